// File: rtl/pmod_led_pkg.sv
// pmod_led_pkg: state encoding, phase counts and bit-order helper for the LED bus serializer.
// LED_SER_MSB_FIRST_EN selects MSB-first bit order in bit_at(); default is LSB first.
package pmod_led_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BITLO,
      BITHI,
      HOLD,
      STOP
   } state_t;

   localparam int START_PHASES = 2;
   localparam int BIT_PHASES   = 16;
   localparam int STOP_PHASES  = 3;
   localparam int BYTE_BITS    = BIT_PHASES / 2;

   // Wire-order bit n of a byte.
   function automatic logic bit_at(input logic [7:0] d, input logic [2:0] n);
`ifdef LED_SER_MSB_FIRST_EN
      return d[3'd7 - n];
`else
      return d[n];
`endif
   endfunction

endpackage

// File: rtl/led_ser_tick.sv
// led_ser_tick: divides CLK into bus phases of CLK_DIV clocks.
// tick is high on the last clock of each phase; restart begins a new phase.
module led_ser_tick #(
   parameter int CLK_DIV = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int W = $clog2(CLK_DIV);
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] cnt;

   // Phase counter, wrapping every CLK_DIV clocks or on restart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/led_serial_tx.sv
// led_serial_tx: byte serializer for the two-wire LED driver bus with start/stop framing.
// Bit order is LSB first unless LED_SER_MSB_FIRST_EN is defined.
module led_serial_tx
   import pmod_led_pkg::*;
#(
   parameter int CLK_DIV      = 12,
   parameter int HOLD_TIMEOUT = 4096
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   input  logic       i_last,
   output logic       o_sclk,
   output logic       o_sdat,
   output logic       o_busy,
   output logic       o_drop
);

   localparam int HW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
   localparam logic [HW-1:0] HOLD_LAST =
      HW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

   state_t        state;
   logic [7:0]    data_q;
   logic          last_q;
   logic [2:0]    bit_idx;
   logic [1:0]    step;
   logic [HW-1:0] hcnt;
   logic          accept;
   logic          timeout;
   logic          restart;
   logic          tick;

   assign accept  = i_valid && !o_busy;
   assign timeout = (HOLD_TIMEOUT != 0) && (state == HOLD) && (hcnt == HOLD_LAST);
   assign restart = accept || timeout;

   led_ser_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk    (CLK),
      .rst_n  (RST_N),
      .restart(restart),
      .tick   (tick)
   );

   // Framing FSM with registered bus outputs; an accepted byte beats a hold timeout.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         data_q  <= '0;
         last_q  <= 1'b0;
         bit_idx <= '0;
         step    <= '0;
         hcnt    <= '0;
         o_sclk  <= 1'b1;
         o_sdat  <= 1'b1;
         o_busy  <= 1'b0;
         o_drop  <= 1'b0;
      end else begin
         o_drop <= i_valid && o_busy;
         if (accept) begin
            data_q  <= i_data;
            last_q  <= i_last;
            bit_idx <= '0;
            step    <= '0;
            o_busy  <= 1'b1;
            if (state == HOLD) begin
               state  <= BITLO;
               o_sclk <= 1'b0;
               o_sdat <= bit_at(i_data, 3'd0);
            end else begin
               state  <= START;
               o_sclk <= 1'b1;
               o_sdat <= 1'b0;
            end
         end else if (timeout) begin
            state  <= STOP;
            step   <= '0;
            o_busy <= 1'b1;
            o_sclk <= 1'b0;
            o_sdat <= 1'b0;
         end else if (state == HOLD) begin
            hcnt <= hcnt + HW'(1);
         end else if (tick) begin
            unique case (state)
               START: begin
                  if (step == 2'(START_PHASES - 1)) begin
                     state  <= BITLO;
                     o_sclk <= 1'b0;
                     o_sdat <= bit_at(data_q, 3'd0);
                  end else begin
                     step   <= step + 2'd1;
                     o_sclk <= 1'b0;
                     o_sdat <= 1'b0;
                  end
               end
               BITLO: begin
                  state  <= BITHI;
                  o_sclk <= 1'b1;
               end
               BITHI: begin
                  o_sclk <= 1'b0;
                  if (bit_idx == 3'(BYTE_BITS - 1)) begin
                     o_sdat <= 1'b0;
                     step   <= '0;
                     if (last_q) begin
                        state <= STOP;
                     end else begin
                        state  <= HOLD;
                        hcnt   <= '0;
                        o_busy <= 1'b0;
                     end
                  end else begin
                     state   <= BITLO;
                     bit_idx <= bit_idx + 3'd1;
                     o_sdat  <= bit_at(data_q, bit_idx + 3'd1);
                  end
               end
               STOP: begin
                  if (step == 2'(STOP_PHASES - 1)) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                  end else begin
                     step   <= step + 2'd1;
                     o_sclk <= 1'b1;
                     o_sdat <= (step == 2'(STOP_PHASES - 2));
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
